// File: rtl/skintone_v1_00_a_frame_controller.sv
// Skin-tone pipeline frame controller.
// Accepts a command, loads the per-frame coefficient table into the datapath
// through a single-outstanding config write port, then gates a frame's worth
// of pixel beats into the datapath and waits for all results to drain.
// Optional feature: define SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN to add a
// 16-cycle watchdog on config_wrack that aborts the frame to DONE.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command; accepts one opcode per cycle
// LOAD   | writing coefficient registers 0..C_NUM_REGS-1, one at a time
// STREAM | passing src beats to the datapath until frame_beats are sent
// DRAIN  | waiting for the remaining results to leave through the sink
// DONE   | one-cycle frame-complete pulse, then back to IDLE
module skintone_v1_00_a_frame_controller #(
    parameter int C_NUM_REGS    = 12,
    parameter int C_COUNT_WIDTH = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               opcode,
    input  logic                      opcode_valid,
    output logic                      opcode_accept,
    input  logic [C_COUNT_WIDTH-1:0]  frame_beats,
    input  logic [8*C_NUM_REGS-1:0]   coef_in,
    output logic [35:0]               config_address,
    output logic [127:0]              config_datain,
    output logic                      config_wrreq,
    input  logic                      config_wrack,
    input  logic                      src_valid,
    output logic                      src_ready,
    output logic                      dp_valid,
    input  logic                      dp_ready,
    input  logic                      dp_result_valid,
    output logic                      dp_result_ready,
    input  logic                      sink_ready,
    output logic                      sink_valid,
    output logic                      done,
    output logic [35:0]               status
);

    localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REGS - 1);
    localparam logic [3:0] OP_RUN       = 4'h1;
    localparam logic [3:0] OP_LOAD_ONLY = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic                       run_q, run_d;
    logic [C_COUNT_WIDTH-1:0]   beats_q, beats_d;
    logic [8*C_NUM_REGS-1:0]    coef_q, coef_d;
    logic [C_COUNT_WIDTH-1:0]   in_count_q, in_count_d;
    logic [C_COUNT_WIDTH-1:0]   out_count_q, out_count_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       wait_ack_q, wait_ack_d;
    logic                       wrreq_q, wrreq_d;
    logic [35:0]                addr_q, addr_d;
    logic [127:0]               data_q, data_d;
    logic                       bad_op_q, bad_op_d;
    logic                       wd_flag;
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
    logic [4:0]                 wd_q, wd_d;
    logic                       wd_to_q, wd_to_d;
`endif

    logic accept_c;
    logic done_c;
    logic in_active;
    logic in_beat;
    logic out_beat;

    // Only the command code field has meaning here; the low bits are ignored.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^opcode[11:0];

    assign in_active = (state_q == ST_STREAM) && (in_count_q < beats_q);
    assign in_beat   = in_active && src_valid && dp_ready;
    assign out_beat  = ((state_q == ST_STREAM) || (state_q == ST_DRAIN))
                       && dp_result_valid && sink_ready;

    // Next-state and command/handshake decisions for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        beats_d     = beats_q;
        coef_d      = coef_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        idx_d       = idx_q;
        wait_ack_d  = wait_ack_q;
        wrreq_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        bad_op_d    = bad_op_q;
        accept_c    = 1'b0;
        done_c      = 1'b0;
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
        wd_d        = wd_q;
        wd_to_d     = wd_to_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (opcode_valid) begin
                    accept_c    = 1'b1;
                    beats_d     = frame_beats;
                    coef_d      = coef_in;
                    in_count_d  = '0;
                    out_count_d = '0;
                    idx_d       = '0;
                    wait_ack_d  = 1'b0;
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
                    wd_to_d     = 1'b0;
`endif
                    case (opcode[15:12])
                        OP_RUN: begin
                            run_d    = 1'b1;
                            bad_op_d = 1'b0;
                            state_d  = ST_LOAD;
                        end
                        OP_LOAD_ONLY: begin
                            run_d    = 1'b0;
                            bad_op_d = 1'b0;
                            state_d  = ST_LOAD;
                        end
                        default: begin
                            bad_op_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (!wait_ack_q) begin
                    // Issue the next write; the request is a single-cycle pulse.
                    wrreq_d    = 1'b1;
                    addr_d     = {32'(idx_q), 4'h0};
                    data_d     = {120'b0, coef_q[8*int'(idx_q) +: 8]};
                    wait_ack_d = 1'b1;
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
                    wd_d       = 5'd0;
`endif
                end else if (config_wrack) begin
                    wait_ack_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = run_q ? ST_STREAM : ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
                else if (wd_q == 5'd15) begin
                    wd_to_d    = 1'b1;
                    wait_ack_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    wd_d = wd_q + 5'd1;
                end
`endif
            end
            ST_STREAM: begin
                if (in_beat) begin
                    in_count_d = in_count_q + 1'b1;
                end
                if (out_beat) begin
                    out_count_d = out_count_q + 1'b1;
                end
                // Leave as soon as the last in-beat is taken (or at once for empty frames).
                if (in_count_d == beats_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_beat) begin
                    out_count_d = out_count_q + 1'b1;
                end
                if (out_count_d >= beats_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            beats_q     <= '0;
            coef_q      <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            idx_q       <= '0;
            wait_ack_q  <= 1'b0;
            wrreq_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            bad_op_q    <= 1'b0;
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
            wd_q        <= 5'd0;
            wd_to_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            beats_q     <= beats_d;
            coef_q      <= coef_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            idx_q       <= idx_d;
            wait_ack_q  <= wait_ack_d;
            wrreq_q     <= wrreq_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            bad_op_q    <= bad_op_d;
`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
            wd_q        <= wd_d;
            wd_to_q     <= wd_to_d;
`endif
        end
    end

`ifdef SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN
    assign wd_flag = wd_to_q;
`else
    assign wd_flag = 1'b0;
`endif

    // Combinational strobes are held low while reset is asserted.
    assign opcode_accept   = accept_c & ~rst;
    assign done            = done_c & ~rst;
    assign dp_valid        = in_active & src_valid & ~rst;
    assign src_ready       = in_active & dp_ready & ~rst;

    assign sink_valid      = dp_result_valid;
    assign dp_result_ready = sink_ready;

    assign config_address  = addr_q;
    assign config_datain   = data_q;
    assign config_wrreq    = wrreq_q;

    assign status = 36'({out_count_q, wd_flag, bad_op_q, (state_q != ST_IDLE), 3'(state_q)});

endmodule

// File: doc/skintone_v1_00_a_frame_controller.md
SKINTONE_V1_00_A_FRAME_CONTROLLER -- requirements
Module: skintone_v1_00_a_frame_controller

Interface
REQ-001 SHALL have parameter C_NUM_REGS, default 12: number of 8-bit coefficient registers loaded per frame.
REQ-002 SHALL have parameter C_COUNT_WIDTH, default 18: width of the beat counters and frame_beats.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports opcode, input, 16, and opcode_valid, input, 1: command; opcode[15:12] is the command code.
REQ-006 SHALL have port opcode_accept, output, 1: one-cycle accept pulse.
REQ-007 SHALL have port frame_beats, input, C_COUNT_WIDTH: 128-bit beats per frame, sampled on accept.
REQ-008 SHALL have port coef_in, input, 8*C_NUM_REGS: coefficient table; register i = coef_in[8i+7:8i], sampled on accept.
REQ-009 SHALL have config master ports config_address (output, 36), config_datain (output, 128), config_wrreq (output, 1) and config_wrack (input, 1).
REQ-010 SHALL have ports src_valid (input, 1) and src_ready (output, 1): upstream pixel beats.
REQ-011 SHALL have ports dp_valid (output, 1) and dp_ready (input, 1): gated pixel beats toward the datapath.
REQ-012 SHALL have ports dp_result_valid (input, 1), dp_result_ready (output, 1), sink_ready (input, 1) and sink_valid (output, 1): result path.
REQ-013 SHALL have ports done (output, 1), a one-cycle frame-complete pulse, and status (output, 36).

Function
REQ-014 SHALL implement the states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-015 IDLE: opcode_accept SHALL pulse for one cycle when opcode_valid is high; opcode, frame_beats and coef_in SHALL be captured that cycle.
REQ-016 Code 4'h1 (RUN) SHALL go to LOAD, then to STREAM; code 4'h2 (LOAD_ONLY) SHALL go to LOAD, then to DONE.
REQ-017 Any other code SHALL be accepted, SHALL set sticky status[4], and the block SHALL stay in IDLE; a later RUN or LOAD_ONLY SHALL clear status[4].
REQ-018 Opcodes SHALL NOT be accepted outside IDLE (opcode_accept=0).
REQ-019 LOAD SHALL perform writes for i=0..C_NUM_REGS-1 in order, with at most one outstanding.
REQ-020 Each LOAD write SHALL drive config_address={i[31:0],4'h0} and config_datain={120'b0,reg_i}, and SHALL raise config_wrreq for exactly one cycle.
REQ-021 After each LOAD write the block SHALL wait for config_wrack before the next config_wrreq; a wrack not preceded by a request SHALL be ignored.
REQ-022 STREAM while in_count<frame_beats: dp_valid=src_valid, src_ready=dp_ready; otherwise dp_valid=0 and src_ready=0.
REQ-023 in_count SHALL increment on each dp_valid&dp_ready.
REQ-024 In every state, sink_valid=dp_result_valid and dp_result_ready=sink_ready.
REQ-025 out_count SHALL increment on each dp_result_valid&sink_ready during STREAM or DRAIN.
REQ-026 In-beats and out-beats in the same cycle SHALL both be counted.
REQ-027 STREAM SHALL go to DRAIN in the cycle after in_count reaches frame_beats; frame_beats=0 SHALL go to DRAIN immediately.
REQ-028 DRAIN SHALL go to DONE once out_count==frame_beats.
REQ-029 DONE SHALL assert done for one cycle, then go to IDLE; the counters SHALL clear on the next accept.
REQ-030 status SHALL be: [2:0] state (IDLE=0, LOAD=1, STREAM=2, DRAIN=3, DONE=4), [3] busy (state!=IDLE), [4] bad opcode, [5] wrack timeout, [5+C_COUNT_WIDTH:6] out_count, upper bits 0.

Reset
REQ-031 rst SHALL force state IDLE, clear both counters and status[5:4], and drive opcode_accept, config_wrreq, dp_valid, src_ready and done to 0.
REQ-032 rst SHALL drive config_address and config_datain to 0.
REQ-033 rst mid-LOAD or mid-STREAM SHALL abort with no further config_wrreq or dp_valid.

Configuration
REQ-034 With macro SKINTONE_FRAME_CTRL_WRACK_TIMEOUT_EN defined, a 5-bit watchdog SHALL run while waiting for wrack; 16 cycles without wrack SHALL set sticky status[5] and go to DONE (done pulses); the next accept SHALL clear status[5].
REQ-035 Without the macro, the block SHALL wait for wrack indefinitely, and status[5] SHALL be constant 0.

Verification
REQ-036 RUN, frame_beats=4, wrack 1 cycle after each wrreq, all readies high -> 12 writes to addresses 0x0..0xB0 with the coef bytes; 4 dp beats; done one cycle after the 4th result.
REQ-037 LOAD_ONLY -> 12 writes, then done; dp_valid never asserted; status[2:0] returns to 0.
REQ-038 Opcode 0x7000 -> opcode_accept pulse, status[4]=1, no wrreq; a following RUN clears status[4].
REQ-039 RUN, frame_beats=3, src_valid held high -> exactly 3 dp handshakes, then src_ready=0; with sink_ready low the block stays in DRAIN until 3 results are taken.
REQ-040 With the macro defined and wrack withheld -> done 16 cycles after the wrreq and status[5]=1; without the macro -> the block stays in LOAD.
REQ-041 rst asserted during STREAM after 2 of 8 beats -> next cycle state 0, counters 0, dp_valid 0.
